mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between three requesters: CPU data port, CPU instruction-fetch port and a debug/loader port.
- Sits between the CPU's iaddr/daddr/dwdata/we interface and the memory macro, so the CPU can be built against one physical RAM.
- Each access runs through an IDLE/ISSUE/WAIT/RESP sequencer with a configurable read latency.
- Requesters get a grant pulse, and for reads a registered rvalid pulse with data.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_pick.sv | 26 ++
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// State encoding, port indices and latency counter width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  localparam int NPORT    = 3;
  localparam int PORT_D   = 0;
  localparam int PORT_I   = 1;
  localparam int PORT_DBG = 2;
  localparam int CNT_W    = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select: debug has strict priority, data vs fetch alternate.
// rr_last_i high means the fetch port won the last CPU-side grant.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic             d_req_i,
  input  logic             i_req_i,
  input  logic             dbg_req_i,
  input  logic             rr_last_i,
  output logic [NPORT-1:0] win_o
);

  always_comb begin
    win_o = '0;
    unique case (1'b1)
      dbg_req_i:
        win_o[PORT_DBG] = 1'b1;
      !dbg_req_i && d_req_i && (!i_req_i || rr_last_i):
        win_o[PORT_D] = 1'b1;
      !dbg_req_i && i_req_i && (!d_req_i || !rr_last_i):
        win_o[PORT_I] = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Three-port front end for one single-port memory macro.
// IDLE/ISSUE/WAIT/RESP sequencer with registered memory strobes.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            d_req,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_we,
  output logic            d_gnt,
  output logic            d_rvalid,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  input  logic            dbg_req,
  input  logic [AW-1:0]   dbg_addr,
  input  logic [DW-1:0]   dbg_wdata,
  input  logic [DW/8-1:0] dbg_we,
  output logic            dbg_gnt,
  output logic            dbg_rvalid,
  output logic [DW-1:0]   rdata,
  output logic            mem_en,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_we,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy
);

  state_e            state_q, state_d;
  logic [NPORT-1:0]  win;
  logic [1:0]        port_q, port_d;
  logic              rr_q, rr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              en_q, en_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [DW/8-1:0]   we_q, we_d;
  logic [NPORT-1:0]  gnt_q, gnt_d;
  logic [NPORT-1:0]  rv_q, rv_d;
  logic [DW-1:0]     rdata_q, rdata_d;

  mem_arb_pick u_pick (
    .d_req_i   (d_req),
    .i_req_i   (i_req),
    .dbg_req_i (dbg_req),
    .rr_last_i (rr_q),
    .win_o     (win)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (|win) state_d = ISSUE;
      ISSUE: state_d = (|we_q) ? IDLE : WAIT;
      WAIT:  if (cnt_q == '0) state_d = RESP;
      RESP:  state_d = IDLE;
    endcase
  end

  always_comb begin
    en_d    = 1'b0;
    gnt_d   = '0;
    we_d    = '0;
    rv_d    = '0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    port_d  = port_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (|win) begin
          en_d  = 1'b1;
          gnt_d = win;
          unique case (1'b1)
            win[PORT_DBG]: begin
              port_d  = 2'(PORT_DBG);
              addr_d  = dbg_addr;
              wdata_d = dbg_wdata;
              we_d    = dbg_we;
            end
            win[PORT_D]: begin
              port_d  = 2'(PORT_D);
              addr_d  = d_addr;
              wdata_d = d_wdata;
              we_d    = d_we;
              rr_d    = 1'b0;
            end
            win[PORT_I]: begin
              port_d  = 2'(PORT_I);
              addr_d  = i_addr;
              rr_d    = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ISSUE: cnt_d = CNT_W'(RD_LATENCY - 1);
      WAIT: begin
        if (cnt_q == '0) begin
          rv_d    = NPORT'(1) << port_q;
          rdata_d = mem_rdata;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      port_q  <= '0;
      rr_q    <= 1'b1;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= '0;
      gnt_q   <= '0;
      rv_q    <= '0;
      rdata_q <= '0;
    end else begin
      port_q  <= port_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      gnt_q   <= gnt_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_en     = en_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_we     = we_q;
  assign d_gnt      = gnt_q[PORT_D];
  assign i_gnt      = gnt_q[PORT_I];
  assign dbg_gnt    = gnt_q[PORT_DBG];
  assign d_rvalid   = rv_q[PORT_D];
  assign i_rvalid   = rv_q[PORT_I];
  assign dbg_rvalid = rv_q[PORT_DBG];
  assign rdata      = rdata_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: latency-1 and latency-3 instances, each with
// a memory model that only drives valid data in the right cycle.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        d_req, i_req, dbg_req;
  logic [31:0] d_addr, i_addr, dbg_addr;
  logic [31:0] d_wdata, dbg_wdata, rd_val;
  logic [3:0]  d_we, dbg_we;

  logic        d_gnt1, d_rv1, i_gnt1, i_rv1, dbg_gnt1, dbg_rv1;
  logic        mem_en1, busy1;
  logic [31:0] rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic [3:0]  mem_we1;

  logic        d_gnt3, d_rv3, i_gnt3, i_rv3, dbg_gnt3, dbg_rv3;
  logic        mem_en3, busy3;
  logic [31:0] rdata3, mem_addr3, mem_wdata3, mem_rdata3;
  logic [3:0]  mem_we3;

  logic        en1_p;
  logic [2:0]  en3_p;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .RD_LATENCY(1)) u1 (
    .clk(clk), .reset(reset),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
    .d_gnt(d_gnt1), .d_rvalid(d_rv1),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt1), .i_rvalid(i_rv1),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_we(dbg_we), .dbg_gnt(dbg_gnt1), .dbg_rvalid(dbg_rv1),
    .rdata(rdata1), .mem_en(mem_en1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_we(mem_we1), .mem_rdata(mem_rdata1),
    .busy(busy1)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .RD_LATENCY(3)) u3 (
    .clk(clk), .reset(reset),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
    .d_gnt(d_gnt3), .d_rvalid(d_rv3),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt3), .i_rvalid(i_rv3),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_we(dbg_we), .dbg_gnt(dbg_gnt3), .dbg_rvalid(dbg_rv3),
    .rdata(rdata3), .mem_en(mem_en3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_we(mem_we3), .mem_rdata(mem_rdata3),
    .busy(busy3)
  );

  // Read data is only valid exactly RD_LATENCY cycles after mem_en.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      en1_p <= 1'b0;
      en3_p <= '0;
    end else begin
      en1_p <= mem_en1;
      en3_p <= {en3_p[1:0], mem_en3};
    end
  end

  assign mem_rdata1 = en1_p    ? rd_val : 32'h0BAD0BAD;
  assign mem_rdata3 = en3_p[2] ? rd_val : 32'h0BAD0BAD;

  task automatic chk(input string tag, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_reqs();
    d_req = 0; i_req = 0; dbg_req = 0;
    d_we = '0; dbg_we = '0;
  endtask

  task automatic do_reset();
    clr_reqs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clr_reqs();
    d_addr = '0; i_addr = '0; dbg_addr = '0;
    d_wdata = '0; dbg_wdata = '0; rd_val = '0;
    tick();
    tick();
    chk("rst_ctl1", {56'd0, busy1, mem_en1, d_gnt1, i_gnt1,
        dbg_gnt1, d_rv1, i_rv1, dbg_rv1}, 64'd0);
    chk("rst_dat1", {rdata1, mem_addr1}, 64'd0);
    chk("rst_ctl3", {60'd0, busy3, mem_en3, mem_we3 != 0, rdata3 != 0},
        64'd0);
    reset = 1'b0;

    // single data read, latency 1
    d_req = 1; d_addr = 32'h100; d_we = 4'b0000; rd_val = 32'hDEADBEEF;
    tick();
    chk("rd_issue", {59'd0, d_gnt1, mem_en1, busy1, mem_we1 != 0,
        i_gnt1}, {59'd0, 5'b11100});
    chk("rd_addr", 64'(mem_addr1), 64'h100);
    d_req = 0;
    tick();
    chk("rd_wait", {61'd0, d_gnt1, mem_en1, d_rv1}, 64'd0);
    tick();
    chk("rd_rvalid", 64'(d_rv1), 64'd1);
    chk("rd_data", 64'(rdata1), 64'hDEADBEEF);
    tick();
    chk("rd_done", {62'd0, busy1, d_rv1}, 64'd0);
    chk("rd_hold", 64'(rdata1), 64'hDEADBEEF);

    // data and fetch contend: D, I, D, I
    do_reset();
    d_req = 1; d_addr = 32'h200; i_req = 1; i_addr = 32'h300;
    rd_val = 32'h55AA55AA;
    for (int c = 1; c <= 16; c++) begin
      logic [3:0] e;
      tick();
      e = {c == 1 || c == 9, c == 5 || c == 13,
           c == 3 || c == 11, c == 7 || c == 15};
      chk($sformatf("rr_c%0d", c),
          {60'd0, d_gnt1, i_gnt1, d_rv1, i_rv1}, {60'd0, e});
      if (c == 13) begin
        d_req = 0; i_req = 0;
      end
    end
    tick();

    // debug write beats both CPU ports and leaves rr_last alone
    do_reset();
    dbg_req = 1; dbg_addr = 32'h40; dbg_wdata = 32'h12345678;
    dbg_we = 4'b1111;
    d_req = 1; d_addr = 32'h80; d_we = 4'b0000;
    i_req = 1; i_addr = 32'h90;
    tick();
    chk("dbg_gnt", {60'd0, dbg_gnt1, d_gnt1, i_gnt1, mem_en1},
        {60'd0, 4'b1001});
    chk("dbg_we", 64'(mem_we1), 64'hF);
    chk("dbg_mem", {mem_addr1, mem_wdata1}, {32'h40, 32'h12345678});
    dbg_req = 0; dbg_we = '0;
    tick();
    chk("dbg_turn", {59'd0, dbg_gnt1, d_gnt1, i_gnt1, mem_en1, busy1},
        64'd0);
    chk("dbg_held", {28'd0, mem_we1, mem_addr1}, {28'd0, 4'd0, 32'h40});
    tick();
    chk("d_after", {62'd0, d_gnt1, i_gnt1}, {62'd0, 2'b10});
    chk("d_addr", 64'(mem_addr1), 64'h80);
    d_req = 0;
    tick();
    tick();
    chk("d_rv_only", {61'd0, dbg_rv1, d_rv1, i_rv1}, {61'd0, 3'b010});
    tick();
    tick();
    chk("i_after", {62'd0, i_gnt1, mem_we1 != 0}, {62'd0, 2'b10});
    i_req = 0;
    tick();
    tick();
    tick();

    // fetch read at latency 3; data request raised while busy
    do_reset();
    i_req = 1; i_addr = 32'h300; rd_val = 32'hCAFEF00D;
    tick();
    chk("l3_issue", {61'd0, i_gnt3, mem_en3, mem_we3 != 0},
        {61'd0, 3'b110});
    chk("l3_addr", 64'(mem_addr3), 64'h300);
    i_req = 0;
    d_req = 1; d_addr = 32'h10; d_we = 4'b0000;
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk($sformatf("l3_wait%0d", c),
          {60'd0, d_gnt3, i_gnt3, dbg_gnt3, i_rv3}, 64'd0);
    end
    tick();
    chk("l3_rvalid", 64'(i_rv3), 64'd1);
    chk("l3_data", 64'(rdata3), 64'hCAFEF00D);
    tick();
    chk("l3_idle", {62'd0, busy3, i_rv3}, 64'd0);
    tick();
    chk("l3_d_gnt", 64'(d_gnt3), 64'd1);
    d_req = 0;
    tick();
    tick();
    tick();
    tick();

    // reset during WAIT abandons the read
    do_reset();
    d_req = 1; d_addr = 32'h100; rd_val = 32'h11112222;
    tick();
    chk("ab_gnt", 64'(d_gnt1), 64'd1);
    d_req = 0;
    tick();
    reset = 1'b1;
    #1;
    chk("ab_ctl", {56'd0, busy1, mem_en1, d_gnt1, d_rv1, mem_we1},
        64'd0);
    chk("ab_dat", {rdata1, mem_addr1}, 64'd0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("ab_quiet%0d", c), {62'd0, d_rv1, busy1}, 64'd0);
    end
    d_req = 1; d_addr = 32'h24; rd_val = 32'h24242424;
    tick();
    chk("ab_next_gnt", {63'd0, d_gnt1}, 64'd1);
    d_req = 0;
    tick();
    tick();
    chk("ab_next_rv", {31'd0, d_rv1, rdata1}, {31'd0, 1'b1, 32'h24242424});
    tick();

    // byte-lane write passes straight through
    d_req = 1; d_addr = 32'h203; d_wdata = 32'hAABBCCDD; d_we = 4'b0100;
    tick();
    chk("bw_we", 64'(mem_we1), 64'h4);
    chk("bw_mem", {mem_addr1, mem_wdata1}, {32'h203, 32'hAABBCCDD});
    chk("bw_gnt", {62'd0, d_gnt1, mem_en1}, {62'd0, 2'b11});
    d_req = 0; d_we = '0;
    tick();
    chk("bw_turn", {57'd0, busy1, mem_en1, d_rv1, mem_we1}, 64'd0);
    tick();
    chk("bw_norv", {62'd0, d_rv1, busy1}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
